// File: rtl/ahb_mtx_out_arb.sv
// Round-robin address/data phase arbiter for one AHB bus-matrix output port.
// Ownership is held through continuing bursts and locked sequences.
module ahb_mtx_out_arb #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [NUM_IN-1:0] req_in,
    input  logic [NUM_IN-1:0] hold_in,
    input  logic [NUM_IN-1:0] lock_in,
    input  logic              HREADYM,
    output logic [IDX_W-1:0]  addr_in_port,
    output logic              no_port,
    output logic [NUM_IN-1:0] active_in,
    output logic [IDX_W-1:0]  data_in_port,
    output logic              data_valid
);

    localparam int PAD = 1 << IDX_W;

    logic [IDX_W-1:0] addr_port_reg;
    logic             no_port_reg;
    logic [IDX_W-1:0] last_reg;
    logic [IDX_W-1:0] data_port_reg;
    logic             data_valid_reg;

    logic [PAD-1:0]   req_pad;
    logic [PAD-1:0]   hold_pad;
    logic [PAD-1:0]   lock_pad;
    logic             keep_next;
    logic             rr_hit_next;
    logic [IDX_W-1:0] rr_idx_next;

    // Padding to a power of two keeps the owner index in range for any NUM_IN.
    assign req_pad  = PAD'(req_in);
    assign hold_pad = PAD'(hold_in);
    assign lock_pad = PAD'(lock_in);

    assign keep_next = ~no_port_reg &
                       (lock_pad[addr_port_reg] |
                        (req_pad[addr_port_reg] & hold_pad[addr_port_reg]));

    // Walk from the farthest candidate back to last+1 so the nearest requester wins.
    always_comb begin
        rr_hit_next = 1'b0;
        rr_idx_next = last_reg;
        for (int k = NUM_IN; k >= 1; k--) begin
            int cand;
            cand = int'(last_reg) + k;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (req_in[cand]) begin
                rr_hit_next = 1'b1;
                rr_idx_next = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_port_reg  <= '0;
            no_port_reg    <= 1'b1;
            last_reg       <= IDX_W'(NUM_IN - 1);
            data_port_reg  <= '0;
            data_valid_reg <= 1'b0;
        end else if (HREADYM) begin
            data_port_reg  <= addr_port_reg;
            data_valid_reg <= ~no_port_reg & req_pad[addr_port_reg];
            if (keep_next) begin
                no_port_reg <= 1'b0;
            end else if (rr_hit_next) begin
                addr_port_reg <= rr_idx_next;
                last_reg      <= rr_idx_next;
                no_port_reg   <= 1'b0;
            end else begin
                no_port_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_active
            assign active_in[gi] = ~no_port_reg & (addr_port_reg == IDX_W'(gi));
        end
    endgenerate

    assign addr_in_port = addr_port_reg;
    assign no_port      = no_port_reg;
    assign data_in_port = data_port_reg;
    assign data_valid   = data_valid_reg;

endmodule

// File: tb/tb_ahb_mtx_out_arb.sv
// Directed bench for ahb_mtx_out_arb: vector table plus reset and wait-state sequences.
module tb_ahb_mtx_out_arb;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [2:0] req_in, hold_in, lock_in;
    logic       HREADYM;
    logic [1:0] addr_in_port, data_in_port;
    logic       no_port, data_valid;
    logic [2:0] active_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_mtx_out_arb #(.NUM_IN(3), .IDX_W(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_in(req_in), .hold_in(hold_in), .lock_in(lock_in),
        .HREADYM(HREADYM),
        .addr_in_port(addr_in_port), .no_port(no_port), .active_in(active_in),
        .data_in_port(data_in_port), .data_valid(data_valid)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] hold;
        logic [2:0] lock;
        logic       rdy;
        logic [1:0] e_addr;
        logic       e_nop;
        logic [2:0] e_act;
        logic [1:0] e_dport;
        logic       e_dv;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] ea, input logic en,
                             input logic [2:0] eact, input logic [1:0] ed, input logic edv);
        check({tag, ".addr_in_port"}, 32'(addr_in_port), 32'(ea));
        check({tag, ".no_port"},      32'(no_port),      32'(en));
        check({tag, ".active_in"},    32'(active_in),    32'(eact));
        check({tag, ".data_in_port"}, 32'(data_in_port), 32'(ed));
        check({tag, ".data_valid"},   32'(data_valid),   32'(edv));
        $display("%s: addr=%0d nop=%0b act=%b dport=%0d dv=%0b", tag,
                 addr_in_port, no_port, active_in, data_in_port, data_valid);
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] h, input logic [2:0] l, input logic rd);
        req_in = r; hold_in = h; lock_in = l; HREADYM = rd;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        //           req     hold    lock    rdy   addr nop act     dp  dv
        vecs[0]  = '{3'b010, 3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 3'b010, 2'd0, 1'b0};
        vecs[1]  = '{3'b010, 3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 3'b010, 2'd1, 1'b1};
        vecs[2]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd2, 1'b0, 3'b100, 2'd1, 1'b1};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd2, 1'b1};
        vecs[4]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 3'b010, 2'd0, 1'b1};
        vecs[5]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd2, 1'b0, 3'b100, 2'd1, 1'b1};
        vecs[6]  = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd2, 1'b1};
        vecs[7]  = '{3'b111, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[8]  = '{3'b111, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[9]  = '{3'b111, 3'b001, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd0, 1'b1};
        vecs[10] = '{3'b111, 3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 3'b010, 2'd0, 1'b1};
        vecs[11] = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 1'b1, 3'b000, 2'd1, 1'b0};
        vecs[12] = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd1, 1'b1, 3'b000, 2'd1, 1'b0};
        vecs[13] = '{3'b100, 3'b000, 3'b000, 1'b1, 2'd2, 1'b0, 3'b100, 2'd1, 1'b0};
        vecs[14] = '{3'b001, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0, 3'b100, 2'd2, 1'b0};
        vecs[15] = '{3'b001, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0, 3'b100, 2'd2, 1'b0};
        vecs[16] = '{3'b001, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0, 3'b001, 2'd2, 1'b0};
        vecs[17] = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 1'b1, 3'b000, 2'd0, 1'b0};
        vecs[18] = '{3'b010, 3'b000, 3'b000, 1'b0, 2'd0, 1'b1, 3'b000, 2'd0, 1'b0};
        vecs[19] = '{3'b010, 3'b000, 3'b000, 1'b1, 2'd1, 1'b0, 3'b010, 2'd0, 1'b0};

        req_in = '0; hold_in = '0; lock_in = '0; HREADYM = 1'b1;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        check_all("reset", 2'd0, 1'b1, 3'b000, 2'd0, 1'b0);
        HRESETn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].req, vecs[i].hold, vecs[i].lock, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_nop,
                      vecs[i].e_act, vecs[i].e_dport, vecs[i].e_dv);
        end

        // Wait states with input 1 owning: everything freezes while requests churn.
        for (int i = 0; i < 4; i++) begin
            step(3'(i + 4), 3'(i), 3'(7 - i), 1'b0);
            check_all($sformatf("wait%0d", i), 2'd1, 1'b0, 3'b010, 2'd0, 1'b0);
        end

        // Build owner 2 with data_valid=1, then assert reset mid-cycle.
        step(3'b100, 3'b000, 3'b000, 1'b1);
        check_all("pre_rst_a", 2'd2, 1'b0, 3'b100, 2'd1, 1'b0);
        step(3'b100, 3'b000, 3'b000, 1'b1);
        check_all("pre_rst_b", 2'd2, 1'b0, 3'b100, 2'd2, 1'b1);
        #1 HRESETn = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 1'b1, 3'b000, 2'd0, 1'b0);
        #2 HRESETn = 1'b1;
        step(3'b110, 3'b000, 3'b000, 1'b1);
        check_all("post_rst", 2'd1, 1'b0, 3'b010, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_mtx_out_arb.md
Name: ahb_mtx_out_arb

Overview:
- Round-robin arbiter for one bus-matrix output stage, shared by NUM_IN input stages.
- Decides which input stage owns the output port's address phase and tracks which owns the data phase.
- Holds ownership through undefined/incrementing bursts and locked sequences.
- Drives the per-input `active` indications that feed each input stage's decoder (the decoder's `active_dec` inputs).

Parameters:
- NUM_IN, 3, number of input stages sharing this output port (2..8).
- IDX_W, 2, width of encoded port index; must satisfy 2**IDX_W >= NUM_IN.

Ports:
- HCLK  input  1  AHB system clock
- HRESETn  input  1  asynchronous active-low reset
- req_in  input  NUM_IN  per input: decoder `sel` for this port AND HTRANS != IDLE
- hold_in  input  NUM_IN  per input: HTRANS is SEQ or BUSY (burst continuing)
- lock_in  input  NUM_IN  per input: HMASTLOCK for this port
- HREADYM  input  1  HREADY of the output port (transfer completing this cycle)
- addr_in_port  output  IDX_W  encoded address-phase owner (mux select)
- no_port  output  1  no owner; output port drives HTRANS=IDLE
- active_in  output  NUM_IN  one-hot owner, all zero when no_port=1
- data_in_port  output  IDX_W  encoded data-phase owner
- data_valid  output  1  a granted input's transfer is in its data phase

Behaviour:
- Reset (async, HRESETn=0) values:
  - addr_in_port=0, data_in_port=0
  - no_port=1, data_valid=0
  - active_in=0
  - last-granted pointer = NUM_IN-1, so input 0 has first priority.
- All state updates only on a posedge HCLK with HREADYM=1. While HREADYM=0, every register and output holds, whatever the req/hold/lock values.
- Next-owner decision at an update edge, in priority order; "owner" is the current addr_in_port, valid only when no_port=0:
  1. no_port=0 and lock_in[owner]=1 -> keep owner. This applies even if req_in[owner]=0, so locked IDLE cycles keep the port.
  2. no_port=0 and req_in[owner]=1 and hold_in[owner]=1 -> keep owner (burst continuing).
  3. Any req_in bit set -> owner = first requesting index searching owner+1, owner+2, ... wrapping modulo NUM_IN, with owner itself last. Set no_port=0 and update the last-granted pointer.
  4. Otherwise -> no_port=1; addr_in_port parks at its previous value; pointer unchanged.
- Grant latency: a request raised while idle is granted at the next HREADYM edge. addr_in_port and active_in are registered outputs.
- active_in[i] = ~no_port & (addr_in_port == i); purely decoded from registers.
- Data-phase tracking at each update edge:
  - data_in_port <= addr_in_port
  - data_valid <= ~no_port & req_in[addr_in_port]
- Simultaneous requests: exactly one grant; round-robin guarantees each requester is served within NUM_IN grants.
- A req_in bit dropped by a non-owner before grant has no effect.
- The owner dropping req_in with hold_in=0 and lock_in=0 releases the port at the next update edge.
- Indices >= NUM_IN never appear on addr_in_port; unused one-hot bits stay 0.
- Inputs are ignored while HRESETn=0. Release of reset is synchronous to HCLK; no outputs glitch except on the async assert.

Test Plan:
- Reset mid-operation:
  - Stimulus: owner=2, data_valid=1, then HRESETn pulsed low for 1/3 cycle.
  - Required: immediately no_port=1, active_in=0, addr_in_port=0, data_in_port=0, data_valid=0. After release, req_in=3'b110 grants input 1 first.
- Single request:
  - Stimulus: req_in=3'b010, HREADYM=1.
  - Required: next edge addr_in_port=1, active_in=3'b010, no_port=0. Following edge data_in_port=1, data_valid=1.
- Round-robin:
  - Stimulus: req_in=3'b111 held, hold_in=0, HREADYM=1.
  - Required: grants sequence 0,1,2,0 on consecutive edges. active_in sequence 001,010,100,001.
- Burst hold:
  - Stimulus: input 0 owns, hold_in[0]=1 for 3 edges while req_in=3'b111.
  - Required: addr_in_port stays 0 for those edges. First edge with hold_in[0]=0 grants input 1.
- Lock and wait states:
  - Stimulus: input 2 owns, lock_in[2]=1, req_in[2]=0, req_in[0]=1.
  - Required: owner stays 2. Additionally, with HREADYM=0 for 4 cycles while requests change, all outputs stay constant.
- Release to idle:
  - Stimulus: owner 1 drops req_in, all req_in=0.
  - Required: next edge no_port=1, active_in=0, addr_in_port stays 1. Following edge data_valid=0.
